matmul_tile_scheduler: RTL and testbench

Sequencer for the tiled matrix-multiply datapath. It walks the result matrix in TILE_R×TILE_C output tiles and the inner dimension in TILE_K steps. For each step it launches the block multiplier, then launches the block adder (which accumulates the multiplied block into the result buffer at the current row/column offset), and waits for each unit's done. It sits between the top-level command interface and the two compute units, and it owns all tile index generation.

---
 rtl/matmul_tile_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_matmul_tile_scheduler.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_tile_scheduler.sv
// Tile sequencer for the blocked matrix multiply: walks k, then col, then row, and
// launches multiplier/adder per step. Optional watchdog: define SCHED_TIMEOUT_EN.
`ifndef A_M
`define A_M 4
`endif
`ifndef B_N
`define B_N 4
`endif
`ifndef A_N
`define A_N 4
`endif
`ifndef J
`define J 2
`endif
`ifndef K
`define K 2
`endif

module matmul_tile_scheduler #(
  parameter int unsigned ROWS           = `A_M,
  parameter int unsigned COLS           = `B_N,
  parameter int unsigned INNER          = `A_N,
  parameter int unsigned TILE_R         = `J,
  parameter int unsigned TILE_C         = `K,
  parameter int unsigned TILE_K         = `K,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        mult_start,
  output logic [9:0]  mult_row,
  output logic [9:0]  mult_col,
  output logic [9:0]  mult_k,
  input  logic        mult_done,
  output logic        add_start,
  output logic [9:0]  add_row,
  output logic [9:0]  add_col,
  input  logic        add_done,
  output logic [15:0] step_count
);

  typedef enum logic [2:0] {
    IDLE, MULT_REQ, MULT_WAIT, ADD_REQ, ADD_WAIT, ADVANCE, FINISH
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  row_q, row_d, col_q, col_d, k_q, k_d;
  logic [15:0] step_q, step_d;
  logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic        mstart_q, mstart_d, astart_q, astart_d;
  logic        mdone_prev_q, adone_prev_q;
  logic        mult_rise, add_rise, timeout;
  logic [10:0] k_sum, col_sum, row_sum;

`ifdef SCHED_TIMEOUT_EN
  logic [15:0] wait_cnt_q, wait_cnt_d;

  // Counter is zero on the first wait cycle, so timeout fires after exactly TIMEOUT_CYCLES waits.
  always_comb begin
    timeout    = (32'(wait_cnt_q) + 32'd1) >= TIMEOUT_CYCLES;
    wait_cnt_d = '0;
    if ((state_q == MULT_WAIT || state_q == ADD_WAIT) && state_d == state_q)
      wait_cnt_d = wait_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wait_cnt_q <= '0;
    else     wait_cnt_q <= wait_cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  assign mult_rise = mult_done & ~mdone_prev_q;
  assign add_rise  = add_done & ~adone_prev_q;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    k_d     = k_q;
    step_d  = step_q;
    err_d   = err_q;
    k_sum   = {1'b0, k_q} + 11'(TILE_K);
    col_sum = {1'b0, col_q};
    row_sum = {1'b0, row_q};
    case (state_q)
      IDLE: if (start) begin
        row_d   = '0;
        col_d   = '0;
        k_d     = '0;
        step_d  = '0;
        err_d   = 1'b0;
        state_d = MULT_REQ;
      end
      MULT_REQ:  state_d = MULT_WAIT;
      MULT_WAIT: begin
        if (mult_rise) state_d = ADD_REQ;
        else if (timeout) begin
          err_d   = 1'b1;
          state_d = FINISH;
        end
      end
      ADD_REQ:   state_d = ADD_WAIT;
      ADD_WAIT: begin
        if (add_rise) begin
          step_d  = step_q + 16'd1;
          state_d = ADVANCE;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = FINISH;
        end
      end
      ADVANCE: begin
        if (32'(k_sum) >= INNER) begin
          k_sum   = '0;
          col_sum = col_sum + 11'(TILE_C);
        end
        if (32'(col_sum) >= COLS) begin
          col_sum = '0;
          row_sum = row_sum + 11'(TILE_R);
        end
        k_d     = k_sum[9:0];
        col_d   = col_sum[9:0];
        row_d   = row_sum[9:0];
        state_d = (32'(row_sum) >= ROWS) ? FINISH : MULT_REQ;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d   = (state_d != IDLE);
    mstart_d = (state_d == MULT_REQ);
    astart_d = (state_d == ADD_REQ);
    done_d   = (state_d == FINISH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      row_q        <= '0;
      col_q        <= '0;
      k_q          <= '0;
      step_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      mstart_q     <= 1'b0;
      astart_q     <= 1'b0;
      mdone_prev_q <= 1'b0;
      adone_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      k_q          <= k_d;
      step_q       <= step_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      mstart_q     <= mstart_d;
      astart_q     <= astart_d;
      mdone_prev_q <= mult_done;
      adone_prev_q <= add_done;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = err_q;
  assign mult_start = mstart_q;
  assign add_start  = astart_q;
  assign mult_row   = row_q;
  assign mult_col   = col_q;
  assign mult_k     = k_q;
  assign add_row    = row_q;
  assign add_col    = col_q;
  assign step_count = step_q;

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Scoreboard bench for matmul_tile_scheduler: 4x4x4 instance and a ROWS=3 instance,
// behavioural multiplier/adder peers with adjustable latency and hold.
module tb_matmul_tile_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start_v [2];
  logic       md_v    [2];
  logic       ad_v    [2];
  wire        busy_v  [2];
  wire        done_v  [2];
  wire        err_v   [2];
  wire        ms_v    [2];
  wire        as_v    [2];
  wire [9:0]  mr      [2];
  wire [9:0]  mc      [2];
  wire [9:0]  mk      [2];
  wire [9:0]  ar      [2];
  wire [9:0]  ac      [2];
  wire [15:0] sc      [2];

  matmul_tile_scheduler #(
    .ROWS(4), .COLS(4), .INNER(4), .TILE_R(2), .TILE_C(2), .TILE_K(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .error(err_v[0]), .mult_start(ms_v[0]), .mult_row(mr[0]), .mult_col(mc[0]),
    .mult_k(mk[0]), .mult_done(md_v[0]), .add_start(as_v[0]), .add_row(ar[0]),
    .add_col(ac[0]), .add_done(ad_v[0]), .step_count(sc[0])
  );

  matmul_tile_scheduler #(
    .ROWS(3), .COLS(4), .INNER(4), .TILE_R(2), .TILE_C(2), .TILE_K(2), .TIMEOUT_CYCLES(16)
  ) dut_r3 (
    .clk(clk), .rst(rst), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .error(err_v[1]), .mult_start(ms_v[1]), .mult_row(mr[1]), .mult_col(mc[1]),
    .mult_k(mk[1]), .mult_done(md_v[1]), .add_start(as_v[1]), .add_row(ar[1]),
    .add_col(ac[1]), .add_done(ad_v[1]), .step_count(sc[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endfunction

  // Peer behaviour knobs.
  int mlat = 1, mhold = 1, alat = 1, ahold = 1;
  bit mult_en = 1'b1;
  bit stray_en = 1'b0;

  for (genvar g = 0; g < 2; g++) begin : g_peer
    initial begin
      md_v[g] = 1'b0;
      forever begin
        @(negedge clk);
        if (ms_v[g] && mult_en) begin
          repeat (mlat) @(negedge clk);
          md_v[g] = 1'b1;
          repeat (mhold) @(negedge clk);
          md_v[g] = 1'b0;
        end
      end
    end
    initial begin
      ad_v[g] = 1'b0;
      forever begin
        @(negedge clk);
        if (as_v[g]) begin
          repeat (alat) @(negedge clk);
          ad_v[g] = 1'b1;
          repeat (ahold) @(negedge clk);
          ad_v[g] = 1'b0;
        end else if (stray_en && ms_v[g]) begin
          @(negedge clk);
          ad_v[g] = 1'b1;
          @(negedge clk);
          ad_v[g] = 1'b0;
        end
      end
    end
  end

  typedef struct {
    bit is_done;
    int r;
    int c;
    int k;
    int steps;
    bit err;
    int inst;
  } exp_t;

  exp_t exp_q[$];
  int   last_r [2];
  int   last_c [2];

  // Monitor: pops one expectation per mult_start pulse and per done pulse.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (ms_v[i] === 1'b1) begin
        if (exp_q.size() == 0 || exp_q[0].is_done || exp_q[0].inst != i) begin
          n_cmp++;
          n_bad++;
          $display("FAIL mult_start_unexpected inst%0d: got pulse at (%0d,%0d,%0d), expected none",
                   i, mr[i], mc[i], mk[i]);
        end else begin
          e = exp_q.pop_front();
          chk("mult_row", 32'(mr[i]), e.r);
          chk("mult_col", 32'(mc[i]), e.c);
          chk("mult_k", 32'(mk[i]), e.k);
          chk("step_count_at_mult", 32'(sc[i]), e.steps);
          last_r[i] = e.r;
          last_c[i] = e.c;
        end
      end
      if (as_v[i] === 1'b1) begin
        chk("add_row", 32'(ar[i]), last_r[i]);
        chk("add_col", 32'(ac[i]), last_c[i]);
      end
      if (done_v[i] === 1'b1) begin
        if (exp_q.size() == 0 || !exp_q[0].is_done || exp_q[0].inst != i) begin
          n_cmp++;
          n_bad++;
          $display("FAIL done_unexpected inst%0d: got done pulse, expected none", i);
        end else begin
          e = exp_q.pop_front();
          chk("step_count_at_done", 32'(sc[i]), e.steps);
          chk("error_at_done", 32'(err_v[i]), 32'(e.err));
        end
      end
    end
  end

  task automatic push_run(input int inst, input int rows);
    int n = 0;
    for (int r = 0; r < rows; r += 2)
      for (int c = 0; c < 4; c += 2)
        for (int k = 0; k < 4; k += 2) begin
          exp_q.push_back('{is_done: 1'b0, r: r, c: c, k: k, steps: n, err: 1'b0, inst: inst});
          n++;
        end
    exp_q.push_back('{is_done: 1'b1, r: 0, c: 0, k: 0, steps: n, err: 1'b0, inst: inst});
  endtask

  // Called at a negedge; returns cycles from start sample to done (-1 if none).
  task automatic launch(input int inst, input int max_cyc, input int poke, output int lat);
    lat = -1;
    start_v[inst] = 1'b1;
    for (int n = 1; n <= max_cyc; n++) begin
      @(negedge clk);
      start_v[inst] = 1'b0;
      if (n == poke) start_v[inst] = 1'b1;
      if (n == 1) begin
        chk("busy_after_start", 32'(busy_v[inst]), 1);
        chk("mult_start_after_start", 32'(ms_v[inst]), 1);
        chk("error_cleared_by_start", 32'(err_v[inst]), 0);
      end
      if (done_v[inst] === 1'b1) begin
        lat = n;
        break;
      end
    end
    start_v[inst] = 1'b0;
    if (lat < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_wait: got no done within %0d cycles, expected a done pulse", max_cyc);
    end
    @(negedge clk);
    chk("busy_after_done", 32'(busy_v[inst]), 0);
    chk("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    int lat;
    int nadd;
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_v[0]), 0);
    chk("rst_done", 32'(done_v[0]), 0);
    chk("rst_error", 32'(err_v[0]), 0);
    chk("rst_mult_start", 32'(ms_v[0]), 0);
    chk("rst_add_start", 32'(as_v[0]), 0);
    chk("rst_step_count", 32'(sc[0]), 0);
    chk("rst_mult_row", 32'(mr[0]), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic 4x4x4 run with immediate peers.
    push_run(0, 4);
    launch(0, 200, 0, lat);
    chk("basic_latency", lat, 41);
    repeat (4) @(negedge clk);

    // ROWS=3: only rows 0 and 2 issued.
    push_run(1, 3);
    launch(1, 200, 0, lat);
    chk("partial_latency", lat, 41);
    repeat (4) @(negedge clk);

    // Slow, level-held done signals.
    mlat = 1; mhold = 5; alat = 6; ahold = 3;
    push_run(0, 4);
    launch(0, 400, 0, lat);
    repeat (12) @(negedge clk);

    // Start poked while busy plus a stray add_done in every MULT_WAIT.
    mlat = 3; mhold = 1; alat = 1; ahold = 1; stray_en = 1'b1;
    push_run(0, 4);
    launch(0, 300, 7, lat);
    chk("stray_latency", lat, 57);
    stray_en = 1'b0;
    mlat = 1;
    repeat (6) @(negedge clk);

    // Reset in the third ADD_WAIT, then a clean rerun.
    alat = 3;
    push_run(0, 4);
    start_v[0] = 1'b1;
    nadd = 0;
    for (int n = 0; n < 200 && nadd < 3; n++) begin
      @(negedge clk);
      start_v[0] = 1'b0;
      if (as_v[0]) nadd++;
    end
    chk("third_add_reached", nadd, 3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy_v[0]), 0);
    chk("midrst_mult_start", 32'(ms_v[0]), 0);
    chk("midrst_add_start", 32'(as_v[0]), 0);
    chk("midrst_done", 32'(done_v[0]), 0);
    chk("midrst_step_count", 32'(sc[0]), 0);
    chk("midrst_mult_col", 32'(mc[0]), 0);
    chk("midrst_add_col", 32'(ac[0]), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    alat = 1;
    repeat (8) @(negedge clk);
    push_run(0, 4);
    launch(0, 200, 0, lat);
    chk("rerun_latency", lat, 41);
    repeat (4) @(negedge clk);

`ifdef SCHED_TIMEOUT_EN
    // Multiplier never answers: watchdog ends the run with error set.
    mult_en = 1'b0;
    exp_q.push_back('{is_done: 1'b0, r: 0, c: 0, k: 0, steps: 0, err: 1'b0, inst: 0});
    exp_q.push_back('{is_done: 1'b1, r: 0, c: 0, k: 0, steps: 0, err: 1'b1, inst: 0});
    launch(0, 100, 0, lat);
    chk("timeout_latency", lat, 18);
    chk("error_sticky", 32'(err_v[0]), 1);
    mult_en = 1'b1;
    repeat (3) @(negedge clk);
    push_run(0, 4);
    launch(0, 200, 0, lat);
    chk("after_timeout_latency", lat, 41);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_watchdog: got no completion by 200000 time units, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
